// File: rtl/cpu_stage_sequencer.sv
// rtl/cpu_stage_sequencer.sv - stage strobe sequencer with edge-latched fixed-priority interrupts
// Optional memory-wait timeout and bus_error pulse: define SEQ_TIMEOUT_EN.
module cpu_stage_sequencer #(
  parameter int ADDR_W      = 27,
  parameter int NUM_INT     = 4,
  parameter int INT_ID_W    = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          instr_op,
  input  logic                mem_done,
  input  logic [NUM_INT-1:0]  int_req,
  input  logic [ADDR_W-1:0]   pc_in,
  output logic                fetch,
  output logic                get_regs,
  output logic                read_mem,
  output logic                write_back,
  output logic                int_take,
  output logic [INT_ID_W-1:0] int_id,
  output logic [ADDR_W-1:0]   int_pc,
  output logic                int_active,
  output logic                bus_error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_INT    = 3'd5;

  localparam logic [3:0] OP_RETI  = 4'b0001;
  localparam logic [3:0] OP_COPY  = 4'b1100;
  localparam logic [3:0] OP_WRITE = 4'b1101;
  localparam logic [3:0] OP_READ  = 4'b1110;

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic                r_entry;
  logic [NUM_INT-1:0]  r_req_q;
  logic [NUM_INT-1:0]  r_pending;
  logic [NUM_INT-1:0]  w_rise;
  logic [NUM_INT-1:0]  w_clr;
  logic [INT_ID_W-1:0] w_int_idx;
  logic                w_waiting;
  logic                w_timeout;
  logic                w_advance;
  logic                w_reti;
  logic                w_go_int;

  always_comb begin
    w_waiting = 1'b0;
    case (r_state)
      S_FETCH: w_waiting = 1'b1;
      S_MEM:   w_waiting = (instr_op == OP_READ) || (instr_op == OP_COPY);
      S_WB:    w_waiting = (instr_op == OP_WRITE) || (instr_op == OP_COPY);
      default: w_waiting = 1'b0;
    endcase
  end

  // mem_done is only honoured once the waiting state has been held for a cycle
  assign w_advance = w_waiting ? (w_timeout || (!r_entry && mem_done)) : 1'b1;
  assign w_reti    = (r_state == S_WB) && w_advance && (instr_op == OP_RETI);
  assign w_go_int  = (|r_pending) && (!int_active || w_reti);
  assign w_rise    = int_req & ~r_req_q;

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = w_advance ? S_DECODE : S_FETCH;
      S_DECODE: w_next = S_MEM;
      S_MEM:    w_next = w_advance ? S_WB : S_MEM;
      S_WB:     w_next = w_advance ? (w_go_int ? S_INT : S_FETCH) : S_WB;
      S_INT:    w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_int_idx = '0;
    w_clr     = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_int_idx = INT_ID_W'(i);
        w_clr     = '0;
        w_clr[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_entry    <= 1'b1;
      r_req_q    <= '0;
      r_pending  <= '0;
      int_id     <= '0;
      int_pc     <= '0;
      int_active <= 1'b0;
    end else begin
      r_state <= w_next;
      r_entry <= (w_next != r_state);
      r_req_q <= int_req;
      if (r_state == S_INT) begin
        // a fresh edge on the line being cleared keeps it pending
        r_pending  <= (r_pending & ~w_clr) | w_rise;
        int_id     <= w_int_idx;
        int_pc     <= pc_in;
        int_active <= 1'b1;
      end else begin
        r_pending <= r_pending | w_rise;
        if (w_reti) int_active <= 1'b0;
      end
    end
  end

  assign fetch      = (r_state == S_FETCH);
  assign get_regs   = (r_state == S_DECODE);
  assign read_mem   = (r_state == S_MEM);
  assign write_back = (r_state == S_WB);
  assign int_take   = (r_state == S_INT);

`ifdef SEQ_TIMEOUT_EN
  localparam int TCNT_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int TCNT_W   = (TCNT_RAW < 8) ? 8 : ((TCNT_RAW > 32) ? 32 : TCNT_RAW);

  logic [TCNT_W-1:0] r_tcnt;

  assign w_timeout = w_waiting && (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));
  assign bus_error = w_timeout && !(mem_done && !r_entry);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcnt <= '0;
    end else if ((w_next != r_state) || !w_waiting) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign bus_error        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

endmodule
